// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: segment patterns and a width helper.
// Latency: n/a (constants and a compile-time function only).
// Backpressure: n/a.
// Ports: none (package).
package seg_pkg;

  localparam int SEG_W = 7;

  // Bit 0 is segment a, bit 6 is segment g; 0 lights the segment.
  typedef logic [0:SEG_W-1] seg_t;

  localparam seg_t SEG_0    = 7'b0000001;
  localparam seg_t SEG_1    = 7'b1001111;
  localparam seg_t SEG_2    = 7'b0010010;
  localparam seg_t SEG_3    = 7'b0000110;
  localparam seg_t SEG_4    = 7'b1001100;
  localparam seg_t SEG_5    = 7'b0100100;
  localparam seg_t SEG_6    = 7'b0100000;
  localparam seg_t SEG_7    = 7'b0001111;
  localparam seg_t SEG_8    = 7'b0000000;
  localparam seg_t SEG_9    = 7'b0000100;
  localparam seg_t SEG_A    = 7'b0001000;
  localparam seg_t SEG_B    = 7'b1100000;
  localparam seg_t SEG_C    = 7'b0110001;
  localparam seg_t SEG_D    = 7'b1000010;
  localparam seg_t SEG_E    = 7'b0110000;
  localparam seg_t SEG_F    = 7'b0111000;
  localparam seg_t SEG_DASH = 7'b1111110;
  localparam seg_t SEG_OFF  = 7'b1111111;

  // Ceiling log2, evaluated at elaboration time only.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational 4-bit code to active-low seven-segment pattern, with hex/decimal rendering of 10-15.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: code_i (digit code), hex_mode_i (1 = A-F, 0 = dash for 10-15), seg_o (abcdefg, active-low).
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       hex_mode_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (code_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = hex_mode_i ? SEG_A : SEG_DASH;
      4'hB: seg_o = hex_mode_i ? SEG_B : SEG_DASH;
      4'hC: seg_o = hex_mode_i ? SEG_C : SEG_DASH;
      4'hD: seg_o = hex_mode_i ? SEG_D : SEG_DASH;
      4'hE: seg_o = hex_mode_i ? SEG_E : SEG_DASH;
      4'hF: seg_o = hex_mode_i ? SEG_F : SEG_DASH;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode seven-segment driver: per-digit dp, blink, leading-zero blanking, hex mode.
// Latency: 1 clk from scan select or input change to pins (seg, dp, an registered together).
// Backpressure: none; inputs are sampled live every cycle.
// Ports: clk, RESET (sync, active-high), digits (4 bits per digit, digit 0 rightmost), dp_in,
//        blink_en, blank_lz, hex_mode in; seg[0:6] (abcdefg), dp, an (one-hot-low) out, all active-low.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_TICKS = 250
) (
  input  logic                    clk,
  input  logic                    RESET,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    blank_lz,
  input  logic                    hex_mode,
  output logic [0:SEG_W-1]        seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int TW = (clog2(REFRESH_DIV) < 1) ? 1 : clog2(REFRESH_DIV);
  localparam int SW = (clog2(NUM_DIGITS)  < 1) ? 1 : clog2(NUM_DIGITS);
  localparam int BW = (clog2(BLINK_TICKS) < 1) ? 1 : clog2(BLINK_TICKS);

  logic [TW-1:0]         timer_q, timer_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  scan_tick;
  logic [3:0]            cur_code;
  logic                  cur_dp;
  logic                  cur_blink;
  logic                  lz_hit;
  logic                  upper_zero;
  logic                  blank;
  seg_t                  dec_seg;

  assign scan_tick = (timer_q == TW'(REFRESH_DIV - 1));

  // Scan timing: dwell timer, digit select and blink phase all advance on the same tick.
  always_comb begin
    timer_d       = timer_q + 1'b1;
    sel_d         = sel_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (scan_tick) begin
      timer_d = '0;
      sel_d   = (sel_q == SW'(NUM_DIGITS - 1)) ? '0 : sel_q + 1'b1;
      if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Digit mux plus leading-zero detection. Walking from the most significant
  // digit down, upper_zero tells whether every digit above position i is zero.
  always_comb begin
    cur_code   = '0;
    cur_dp     = 1'b0;
    cur_blink  = 1'b0;
    lz_hit     = 1'b0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (sel_q == SW'(i)) begin
        cur_code  = digits[4*i +: 4];
        cur_dp    = dp_in[i];
        cur_blink = blink_en[i];
        // Digit 0 always shows, so an all-zero value still reads "0".
        lz_hit    = (i != 0) && upper_zero && (digits[4*i +: 4] == 4'd0);
      end
      upper_zero = upper_zero && (digits[4*i +: 4] == 4'd0);
    end
  end

  seg_decoder u_dec (
    .code_i     (cur_code),
    .hex_mode_i (hex_mode),
    .seg_o      (dec_seg)
  );

  assign blank = (cur_blink && blink_phase_q) || (blank_lz && lz_hit);

  always_comb begin
    an_d  = ~(NUM_DIGITS'(1) << sel_q);
    seg_d = dec_seg;
    dp_d  = ~cur_dp;
    if (blank) begin
      an_d  = '1;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      timer_q       <= '0;
      sel_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= '1;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
    end else begin
      timer_q       <= timer_d;
      sel_q         <= sel_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: a 4-digit and a 6-digit instance, directed vectors with hand-computed pins.
// Latency: expectations are tagged with the clock edge whose registered output they describe.
// Backpressure: none; a monitor pops and compares expectations on each falling edge.
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 4-digit instance, REFRESH_DIV=4, BLINK_TICKS=2
  logic        rst4;
  logic [15:0] digits4;
  logic [3:0]  dp_in4, blink4;
  logic        lz4, hex4;
  logic [0:6]  seg4;
  logic        dp4;
  logic [3:0]  an4;

  // 6-digit instance, REFRESH_DIV=3, BLINK_TICKS=2
  logic        rst6;
  logic [23:0] digits6;
  logic [5:0]  dp_in6, blink6;
  logic        lz6, hex6;
  logic [0:6]  seg6;
  logic        dp6;
  logic [5:0]  an6;

  seg_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLINK_TICKS(2)) dut4 (
    .clk(clk), .RESET(rst4), .digits(digits4), .dp_in(dp_in4), .blink_en(blink4),
    .blank_lz(lz4), .hex_mode(hex4), .seg(seg4), .dp(dp4), .an(an4)
  );

  seg_scan_mux #(.NUM_DIGITS(6), .REFRESH_DIV(3), .BLINK_TICKS(2)) dut6 (
    .clk(clk), .RESET(rst6), .digits(digits6), .dp_in(dp_in6), .blink_en(blink6),
    .blank_lz(lz6), .hex_mode(hex6), .seg(seg6), .dp(dp6), .an(an6)
  );

  typedef struct {
    int         dut;
    int         cyc;
    logic [5:0] an;
    logic [0:6] seg;
    logic       dp;
    string      nm;
  } exp_t;

  exp_t queue_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation due at the edge just taken.
  always @(negedge clk) begin
    while (queue_q.size() > 0 && queue_q[0].cyc <= cyc) begin
      exp_t e;
      logic [5:0] act_an;
      logic [0:6] act_seg;
      logic       act_dp;
      e = queue_q.pop_front();
      if (e.dut == 4) begin
        act_an = {2'b11, an4}; act_seg = seg4; act_dp = dp4;
      end else begin
        act_an = an6; act_seg = seg6; act_dp = dp6;
      end
      n_checks++;
      if (e.cyc == cyc && act_an === e.an && act_seg === e.seg && act_dp === e.dp)
        n_pass++;
      else
        $display("FAIL %s @cyc %0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b (due cyc %0d)",
                 e.nm, cyc, act_an, act_seg, act_dp, e.an, e.seg, e.dp, e.cyc);
    end
  end

  // Queue the expected pins for the next edge, then move past it.
  task automatic step(input int dut, input logic [5:0] a, input logic [0:6] s,
                      input logic d, input string nm);
    exp_t e;
    e.dut = dut; e.cyc = cyc + 1; e.an = a; e.seg = s; e.dp = d; e.nm = nm;
    queue_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // One 4-cycle dwell of the 4-digit instance with fixed inputs and fixed expected pins.
  task automatic period4(input logic [15:0] dg, input logic [3:0] dpi, input logic [3:0] bl,
                         input logic lz, input logic hx, input logic [3:0] a,
                         input logic [0:6] s, input logic d, input string nm);
    digits4 = dg; dp_in4 = dpi; blink4 = bl; lz4 = lz; hex4 = hx;
    for (int k = 0; k < 4; k++) step(4, {2'b11, a}, s, d, nm);
  endtask

  localparam logic [0:6] OFF = 7'b1111111;

  initial begin
    rst4 = 1'b1; digits4 = 16'h0; dp_in4 = '0; blink4 = '0; lz4 = 1'b0; hex4 = 1'b0;
    rst6 = 1'b1; digits6 = 24'h543210; dp_in6 = '0; blink6 = '0; lz6 = 1'b0; hex6 = 1'b0;
    @(posedge clk);
    #2;

    // Reset held: blank pins.
    for (int k = 0; k < 3; k++) step(4, 6'b111111, OFF, 1'b1, "reset_hold");
    rst4 = 1'b0;

    // Plain scan of 1234 with dp on digit 2, then wrap to slot 0.
    period4(16'h1234, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b1110, 7'b1001100, 1'b1, "scan_s0");
    period4(16'h1234, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b1101, 7'b0000110, 1'b1, "scan_s1");
    period4(16'h1234, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b1011, 7'b0010010, 1'b0, "scan_s2_dp");
    period4(16'h1234, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0111, 7'b1001111, 1'b1, "scan_s3");
    period4(16'h1234, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b1110, 7'b1001100, 1'b1, "scan_wrap");

    // Leading-zero blanking on 0070 and 0000.
    period4(16'h0070, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1101, 7'b0001111, 1'b1, "lz70_s1");
    period4(16'h0070, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1111, OFF,        1'b1, "lz70_s2");
    period4(16'h0070, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1111, OFF,        1'b1, "lz70_s3");
    period4(16'h0070, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1110, 7'b0000001, 1'b1, "lz70_s0");
    period4(16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1111, OFF,        1'b1, "lz0_s1");
    period4(16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1111, OFF,        1'b1, "lz0_s2");
    period4(16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1111, OFF,        1'b1, "lz0_s3");
    period4(16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1110, 7'b0000001, 1'b1, "lz0_s0");

    // Codes 10-15 in decimal and hex mode.
    period4(16'h00A0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1101, 7'b1111110, 1'b1, "dash_A");
    period4(16'h00A0, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b1111, OFF,        1'b1, "lz_above_A");
    period4(16'h00A0, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b1111, OFF,        1'b1, "lz_top");
    period4(16'h000A, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1110, 7'b0001000, 1'b1, "hex_A");
    period4(16'h00F0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1101, 7'b0111000, 1'b1, "hex_F");
    period4(16'h0B00, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1011, 7'b1100000, 1'b1, "hex_b");
    period4(16'hC000, 4'b1000, 4'b0000, 1'b0, 1'b1, 4'b0111, 7'b0110001, 1'b0, "hex_C_dp");

    // Blink: phase 0 on dwells 0-1, phase 1 on dwells 2-3 of each scan here.
    period4(16'h1234, 4'b0000, 4'b0101, 1'b0, 1'b0, 4'b1110, 7'b1001100, 1'b1, "blink_s0_lit");
    period4(16'h1234, 4'b0000, 4'b0101, 1'b0, 1'b0, 4'b1101, 7'b0000110, 1'b1, "blink_s1_lit");
    period4(16'h1234, 4'b0000, 4'b0101, 1'b0, 1'b0, 4'b1111, OFF,        1'b1, "blink_s2_off");
    period4(16'h1234, 4'b0000, 4'b0101, 1'b0, 1'b0, 4'b0111, 7'b1001111, 1'b1, "blink_s3_lit");

    // Zero digit under a nonzero upper digit stays lit; more codes.
    period4(16'hD00E, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b1110, 7'b0110000, 1'b1, "hex_E");
    period4(16'hD00E, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b1101, 7'b0000001, 1'b1, "lz_inner0");
    period4(16'h0900, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1011, 7'b0000100, 1'b1, "dec_9");
    period4(16'h8000, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0111, 7'b0000000, 1'b1, "dec_8");

    // Reset in the middle of slot 2.
    period4(16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1110, 7'b1001100, 1'b1, "pre_s0");
    period4(16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1101, 7'b0000110, 1'b1, "pre_s1");
    step(4, 6'b111011, 7'b0010010, 1'b1, "pre_s2");
    rst4 = 1'b1;
    step(4, 6'b111111, OFF, 1'b1, "mid_reset");
    rst4 = 1'b0;
    // All digits blink after reset: slots 0-1 lit proves phase restarted at 0.
    period4(16'h1234, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b1110, 7'b1001100, 1'b1, "post_s0_full");
    period4(16'h1234, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b1101, 7'b0000110, 1'b1, "post_s1");
    period4(16'h1234, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b1111, OFF,        1'b1, "post_s2_blink");

    // 6-digit instance: walk all slots in 3-cycle dwells, then wrap.
    step(6, 6'b111111, OFF, 1'b1, "w6_reset");
    rst6 = 1'b0;
    begin
      logic [0:6] pat [6];
      pat[0] = 7'b0000001; pat[1] = 7'b1001111; pat[2] = 7'b0010010;
      pat[3] = 7'b0000110; pat[4] = 7'b1001100; pat[5] = 7'b0100100;
      for (int s = 0; s < 7; s++) begin
        logic [5:0] a;
        a = 6'b111111;
        a[s % 6] = 1'b0;
        for (int k = 0; k < 3; k++) step(6, a, pat[s % 6], 1'b1, "w6_walk");
      end
    end

    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (queue_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, want 0", queue_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
